icache: RTL and testbench

Direct-mapped, read-only instruction cache between the fetch stage (PC) and `imem`. Serves hits combinationally in the request cycle. On a miss, stalls fetch and refills the whole line from `imem`, one word per cycle. `imem` is combinational and word-addressed, so the refill engine drives a word index and captures `inst_o` in the same cycle.

---
 rtl/icache_pkg.sv | 38 +++
 rtl/icache_array.sv | 54 +++++
 rtl/icache.sv | 119 +++++++++++
 tb/tb_icache.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types, width helpers and address-field extraction for the direct-mapped icache.
// Fields are returned right-aligned in 32 bits; callers size-cast to the field width.
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_e;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int OFFSET_W = 2;

  function automatic int calc_word_w(int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int calc_index_w(int lines);
    return $clog2(lines);
  endfunction

  function automatic int calc_tag_w(int lines, int words_per_line);
    return ADDR_W - OFFSET_W - $clog2(words_per_line) - $clog2(lines);
  endfunction

  function automatic logic [31:0] addr_word(logic [31:0] addr, int word_w);
    return (addr >> OFFSET_W) & ((32'd1 << word_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(logic [31:0] addr, int word_w, int index_w);
    return (addr >> (OFFSET_W + word_w)) & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(logic [31:0] addr, int word_w, int index_w);
    return addr >> (OFFSET_W + word_w + index_w);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for the icache: async read, one write port, bulk valid clear.
// Only the valid bits are reset; tag and data contents are don't-care until validated.
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int INDEX_W        = 4,
  parameter int WORD_W         = 2,
  parameter int TAG_W          = 24
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [WORD_W-1:0]  rd_word,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [WORD_W-1:0]  wr_word,
  input  logic               data_we,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               tag_we,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               inval_line,
  input  logic               clear_all
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][WORDS_PER_LINE];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_word];

  // A bulk clear overrides any same-edge line update so a flush never leaves a valid line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else begin
      if (inval_line) valid_q[wr_index] <= 1'b0;
      if (tag_we)     valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (data_we) data_q[wr_index][wr_word] <= wr_data;
    if (tag_we)  tag_q[wr_index] <= wr_tag;
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hits, whole-line refill
// from a combinational word-addressed imem, one word per cycle.
module icache
  import icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_req_i,
  input  logic [31:0] cpu_addr_i,
  input  logic        flush_i,
  output logic [31:0] cpu_inst_o,
  output logic        cpu_valid_o,
  output logic        stall_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_inst_i,
  output logic        state_o
);

  localparam int WORD_W  = calc_word_w(WORDS_PER_LINE);
  localparam int INDEX_W = calc_index_w(LINES);
  localparam int TAG_W   = calc_tag_w(LINES, WORDS_PER_LINE);

  // Handshake: cpu_req_i is held with a stable cpu_addr_i while stall_o=1; an instruction
  // is accepted only in a cycle where cpu_valid_o=1. imem answers in the same cycle.

  icache_state_e state_q;
  logic [WORD_W-1:0]        cnt_q;
  logic [TAG_W+INDEX_W-1:0] miss_addr_q;

  logic [WORD_W-1:0]  cpu_word;
  logic [INDEX_W-1:0] cpu_index;
  logic [TAG_W-1:0]   cpu_tag;
  logic [INDEX_W-1:0] miss_index;
  logic [TAG_W-1:0]   miss_tag;

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [DATA_W-1:0]  rd_data;

  logic refill, hit, last_word, miss_start, data_we, tag_we;
  logic [INDEX_W-1:0] wr_index;

  assign cpu_word  = WORD_W'(addr_word(cpu_addr_i, WORD_W));
  assign cpu_index = INDEX_W'(addr_index(cpu_addr_i, WORD_W, INDEX_W));
  assign cpu_tag   = TAG_W'(addr_tag(cpu_addr_i, WORD_W, INDEX_W));
  assign miss_index = miss_addr_q[INDEX_W-1:0];
  assign miss_tag   = miss_addr_q[TAG_W+INDEX_W-1:INDEX_W];

  assign refill     = (state_q == REFILL);
  assign hit        = !refill && cpu_req_i && rd_valid && (rd_tag == cpu_tag);
  assign last_word  = (cnt_q == WORD_W'(WORDS_PER_LINE - 1));
  // Flush wins over a simultaneous miss: the request is re-evaluated next cycle.
  assign miss_start = !refill && cpu_req_i && !hit && !flush_i;
  assign data_we    = refill && !flush_i;
  assign tag_we     = data_we && last_word;
  assign wr_index   = refill ? miss_index : cpu_index;

  icache_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .INDEX_W        (INDEX_W),
    .WORD_W         (WORD_W),
    .TAG_W          (TAG_W)
  ) u_array (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rd_index   (cpu_index),
    .rd_word    (cpu_word),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_index   (wr_index),
    .wr_word    (cnt_q),
    .data_we    (data_we),
    .wr_data    (mem_inst_i),
    .tag_we     (tag_we),
    .wr_tag     (miss_tag),
    .inval_line (miss_start),
    .clear_all  (flush_i)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      miss_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_start) begin
            state_q     <= REFILL;
            cnt_q       <= '0;
            miss_addr_q <= {cpu_tag, cpu_index};
          end
        end
        REFILL: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (last_word) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held, even if fetch keeps requesting.
  assign cpu_valid_o = rst_ni && hit;
  assign cpu_inst_o  = (rst_ni && hit) ? rd_data : 32'd0;
  assign stall_o     = rst_ni && (refill || (cpu_req_i && !hit));
  assign mem_addr_o  = refill ? 32'({miss_addr_q, cnt_q}) : 32'd0;
  assign state_o     = refill;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache with a combinational imem model and hand-computed expectations.
module tb_icache;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cpu_req_i;
  logic [31:0] cpu_addr_i;
  logic        flush_i;
  logic [31:0] cpu_inst_o;
  logic        cpu_valid_o;
  logic        stall_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_inst_i;
  logic        state_o;

  logic [31:0] imem [256];
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  assign mem_inst_i = imem[mem_addr_o[7:0]];

  icache dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cpu_req_i   (cpu_req_i),
    .cpu_addr_i  (cpu_addr_i),
    .flush_i     (flush_i),
    .cpu_inst_o  (cpu_inst_o),
    .cpu_valid_o (cpu_valid_o),
    .stall_o     (stall_o),
    .mem_addr_o  (mem_addr_o),
    .mem_inst_i  (mem_inst_i),
    .state_o     (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue a request that must miss: 1 detect cycle + 4 refill cycles, then a hit.
  task automatic miss_then_hit(input string tag, input logic [31:0] pc, input logic [31:0] exp_inst);
    int stalls;
    logic [31:0] exp_addr;
    for (int k = 0; k < 4; k++) exp_q.push_back(((pc >> 4) << 2) + 32'(k));
    cpu_req_i  = 1'b1;
    cpu_addr_i = pc;
    #1;
    stalls = 0;
    while (stall_o && stalls < 20) begin
      stalls++;
      if (stalls == 1) begin
        check($sformatf("%s_detect_valid", tag), 32'(cpu_valid_o), 32'd0);
        check($sformatf("%s_detect_maddr", tag), mem_addr_o, 32'd0);
      end else begin
        exp_addr = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check($sformatf("%s_maddr%0d", tag, stalls - 2), mem_addr_o, exp_addr);
      end
      tick();
    end
    check($sformatf("%s_stall_cycles", tag), 32'(stalls), 32'd5);
    check($sformatf("%s_exp_q_left", tag), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check($sformatf("%s_hit_valid", tag), 32'(cpu_valid_o), 32'd1);
    check($sformatf("%s_hit_inst", tag), cpu_inst_o, exp_inst);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'hC0DE_0000 | 32'(i);
    imem[0] = 32'h00D0_0793;
    imem[1] = 32'h0387_C713;
    imem[2] = 32'h00E7_E713;

    // Reset state, with fetch already requesting.
    rst_ni = 1'b0; cpu_req_i = 1'b1; cpu_addr_i = 32'h0; flush_i = 1'b0;
    #2;
    check("rst_valid", 32'(cpu_valid_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_maddr", mem_addr_o, 32'd0);
    check("rst_inst", cpu_inst_o, 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    cpu_req_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    check("idle_noreq_stall", 32'(stall_o), 32'd0);

    // Cold miss, then same-line hits with no imem activity.
    miss_then_hit("cold", 32'h0, 32'h00D0_0793);
    tick();
    cpu_addr_i = 32'h4; #1;
    check("hit4_valid", 32'(cpu_valid_o), 32'd1);
    check("hit4_inst", cpu_inst_o, 32'h0387_C713);
    check("hit4_stall", 32'(stall_o), 32'd0);
    check("hit4_maddr", mem_addr_o, 32'd0);
    tick();
    cpu_addr_i = 32'h8; #1;
    check("hit8_valid", 32'(cpu_valid_o), 32'd1);
    check("hit8_inst", cpu_inst_o, 32'h00E7_E713);
    check("hit8_stall", 32'(stall_o), 32'd0);
    tick();

    // Conflict eviction on index 0, then the original line comes back.
    miss_then_hit("evict100", 32'h100, 32'hC0DE_0040);
    tick();
    miss_then_hit("reload0", 32'h0, 32'h00D0_0793);
    tick();

    // Flush in IDLE: the flush cycle still reports the pre-flush hit.
    cpu_addr_i = 32'h0; flush_i = 1'b1; #1;
    check("flush_idle_valid", 32'(cpu_valid_o), 32'd1);
    check("flush_idle_inst", cpu_inst_o, 32'h00D0_0793);
    tick();
    flush_i = 1'b0;
    miss_then_hit("after_flush", 32'h0, 32'h00D0_0793);
    tick();

    // Flush during REFILL at cnt=2 aborts; line 0 must then be invalid.
    cpu_addr_i = 32'h100; #1;
    check("abort_detect_stall", 32'(stall_o), 32'd1);
    tick();
    tick();
    tick();
    flush_i = 1'b1; #1;
    check("abort_cnt2_maddr", mem_addr_o, 32'd66);
    tick();
    flush_i = 1'b0; cpu_req_i = 1'b0; #1;
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_stall", 32'(stall_o), 32'd0);
    check("abort_maddr", mem_addr_o, 32'd0);
    tick();
    miss_then_hit("after_abort", 32'h0, 32'h00D0_0793);
    tick();

    // Simultaneous miss and flush: stall for a cycle, no refill starts.
    cpu_addr_i = 32'h100; flush_i = 1'b1; #1;
    check("flush_miss_stall", 32'(stall_o), 32'd1);
    tick();
    flush_i = 1'b0; #1;
    check("flush_miss_no_refill", 32'(state_o), 32'd0);
    check("flush_miss_restall", 32'(stall_o), 32'd1);
    tick();
    tick();
    tick();
    tick();
    tick();
    check("flush_miss_retry_valid", 32'(cpu_valid_o), 32'd1);
    check("flush_miss_retry_inst", cpu_inst_o, 32'hC0DE_0040);
    tick();

    // Reset asserted at refill cnt=1.
    miss_then_hit("pre_reset", 32'h0, 32'h00D0_0793);
    tick();
    cpu_addr_i = 32'h100; #1;
    tick();
    tick();
    check("rstmid_cnt1_maddr", mem_addr_o, 32'd65);
    rst_ni = 1'b0; #1;
    check("rstmid_valid", 32'(cpu_valid_o), 32'd0);
    check("rstmid_stall", 32'(stall_o), 32'd0);
    check("rstmid_maddr", mem_addr_o, 32'd0);
    check("rstmid_inst", cpu_inst_o, 32'd0);
    tick();
    rst_ni = 1'b1;
    miss_then_hit("after_reset", 32'h0, 32'h00D0_0793);
    tick();

    // Address wobble during REFILL is ignored.
    cpu_req_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; cpu_req_i = 1'b1; cpu_addr_i = 32'h0; #1;
    check("wobble_detect_stall", 32'(stall_o), 32'd1);
    tick();
    cpu_addr_i = 32'h40;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("wobble_maddr%0d", k), mem_addr_o, 32'(k));
      check($sformatf("wobble_stall%0d", k), 32'(stall_o), 32'd1);
      tick();
    end
    check("wobble_40_miss_valid", 32'(cpu_valid_o), 32'd0);
    check("wobble_40_miss_stall", 32'(stall_o), 32'd1);
    cpu_addr_i = 32'h0; #1;
    check("wobble_line0_valid", 32'(cpu_valid_o), 32'd1);
    check("wobble_line0_inst", cpu_inst_o, 32'h00D0_0793);
    tick();
    cpu_req_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
